debounce_tick: RTL

- Conditions a noisy, asynchronous switch/button input into a clean level and a single-cycle enable pulse.
- Sits directly upstream of the enabled D flip-flop stage: db_tick drives that stage's en input, so one physical press produces exactly one capture.
- Contains a 2-flop input synchronizer, a 4-state debounce FSM and an N-bit stability counter.

---
 rtl/debounce_tick_if.sv | 8 +
 rtl/debounce_tick.sv | 60 ++++++
 2 files changed

// File: rtl/debounce_tick_if.sv
// debounce_tick_if: raw switch input and its debounced level/tick outputs
interface debounce_tick_if;
    logic sw;
    logic db_level;
    logic db_tick;
    modport master (output sw, input db_level, db_tick);
    modport slave (input sw, output db_level, db_tick);
endinterface

// File: rtl/debounce_tick.sv
// debounce_tick: 2-flop synchronizer plus 4-state FSM requiring 2^N stable clocks per level change
module debounce_tick #(
    parameter int N = 20
) (
    input logic clk,
    input logic reset,
    debounce_tick_if.slave bus
);
    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;
    state_t state, state_n;
    logic [N-1:0] cnt, cnt_n;
    logic sync1, sync2, tick_n;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.sw;
            sync2 <= sync1;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ZERO;
            cnt <= '0;
            bus.db_level <= 1'b0;
            bus.db_tick <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bus.db_level <= state_n == ONE || state_n == WAIT0;
            bus.db_tick <= tick_n;
        end
    end
    // A state exits at cnt==0, so the down-count never wraps
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        tick_n = 1'b0;
        case (state)
            ZERO: if (sync2) begin
                state_n = WAIT1;
                cnt_n = '1;
            end
            WAIT1: if (!sync2) state_n = ZERO;
            else if (cnt == '0) begin
                state_n = ONE;
                tick_n = 1'b1;
            end else cnt_n = cnt - 1'b1;
            ONE: if (!sync2) begin
                state_n = WAIT0;
                cnt_n = '1;
            end
            WAIT0: if (sync2) state_n = ONE;
            else if (cnt == '0) state_n = ZERO;
            else cnt_n = cnt - 1'b1;
            default: state_n = ZERO;
        endcase
    end
endmodule
